// File: rtl/dest_sel_pipe.sv
// Register-file write-destination selector with a DEPTH-stage valid pipeline,
// stall/flush control, in-flight hazard compare and a sticky bad-select flag.
module dest_sel_pipe #(
  parameter int WIDTH  = 4,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst_f,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_vld,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        chk_addr,
  output logic [WIDTH-1:0]        out,
  output logic                    out_vld,
  output logic                    hazard,
  output logic                    sel_err
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [WIDTH-1:0] r_last_good;
  logic             r_sel_err;

  logic [WIDTH-1:0] w_mux_val;
  logic             w_sel_ok;
  logic             w_hazard;

  // Unused select codes fall back to the last in-range value actually captured.
  always_comb begin
    w_sel_ok  = (int'(sel) < NUM_IN);
    w_mux_val = r_last_good;
    for (int i = 0; i < NUM_IN; i++) begin
      if (int'(sel) == i) w_mux_val = in_bus[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_hazard = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      w_hazard = w_hazard | (r_vld[k] & (r_data[k] == chk_addr));
    end
  end

  // Flush clears only the valid bits; data and last_good keep their values.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      for (int k = 0; k < DEPTH; k++) r_data[k] <= '0;
      r_vld       <= '0;
      r_last_good <= '0;
      r_sel_err   <= 1'b0;
    end else if (flush) begin
      r_vld <= '0;
    end else if (!stall) begin
      r_data[0] <= w_mux_val;
      r_vld[0]  <= in_vld;
      for (int k = 1; k < DEPTH; k++) begin
        r_data[k] <= r_data[k-1];
        r_vld[k]  <= r_vld[k-1];
      end
      if (w_sel_ok) r_last_good <= w_mux_val;
      if (!w_sel_ok && in_vld) r_sel_err <= 1'b1;
    end
  end

  assign out     = r_data[DEPTH-1];
  assign out_vld = r_vld[DEPTH-1];
  assign hazard  = w_hazard;
  assign sel_err = r_sel_err;

endmodule

// File: tb/tb_dest_sel_pipe.sv
// Directed self-checking bench for dest_sel_pipe at WIDTH=4, NUM_IN=3, DEPTH=2.
module tb_dest_sel_pipe;

  logic        clk = 1'b0;
  logic        rst_f;
  logic [11:0] in_bus;
  logic [1:0]  sel;
  logic        in_vld, stall, flush;
  logic [3:0]  chk_addr;
  logic [3:0]  out;
  logic        out_vld, hazard, sel_err;

  int errors = 0;
  int checks = 0;

  dest_sel_pipe #(.WIDTH(4), .NUM_IN(3), .SEL_W(2), .DEPTH(2)) dut (
    .clk(clk), .rst_f(rst_f), .in_bus(in_bus), .sel(sel), .in_vld(in_vld),
    .stall(stall), .flush(flush), .chk_addr(chk_addr), .out(out),
    .out_vld(out_vld), .hazard(hazard), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_f = 1'b0; in_bus = 12'h000; sel = 2'd0; in_vld = 1'b0;
    stall = 1'b0; flush = 1'b0; chk_addr = 4'h0;
    #1;
    check("rst_out",     32'(out),     32'h0);
    check("rst_out_vld", 32'(out_vld), 32'h0);
    check("rst_sel_err", 32'(sel_err), 32'h0);
    check("rst_hazard",  32'(hazard),  32'h0);
    step();
    step();

    // Basic path: select input 1 (7)
    rst_f = 1'b1; in_bus = {4'hC, 4'h7, 4'h3}; sel = 2'd1; in_vld = 1'b1;
    step();
    in_vld = 1'b0;
    check("lat1_vld", 32'(out_vld), 32'h0);
    step();
    check("basic_out", 32'(out),     32'h7);
    check("basic_vld", 32'(out_vld), 32'h1);
    step();
    check("basic_vld_fall", 32'(out_vld), 32'h0);

    // Out-of-range select reuses last_good (7), then in-range C, then hold C
    sel = 2'd3; in_vld = 1'b1;
    step();
    check("oor_sel_err", 32'(sel_err), 32'h1);
    sel = 2'd2;
    step();
    check("oor_out_first", 32'(out), 32'h7);
    check("oor_vld_first", 32'(out_vld), 32'h1);
    sel = 2'd3;
    step();
    check("inrange_out_C", 32'(out), 32'hC);
    sel = 2'd0; in_vld = 1'b0;
    step();
    check("oor_hold_C", 32'(out), 32'hC);
    check("oor_hold_vld", 32'(out_vld), 32'h1);
    check("sel_err_sticky", 32'(sel_err), 32'h1);

    // Stall mid-stream: 1, 2, 3 in order
    in_bus = {4'hC, 4'h7, 4'h1}; sel = 2'd0; in_vld = 1'b1;
    step();
    in_bus[3:0] = 4'h2;
    step();
    check("stream_out1", 32'(out), 32'h1);
    in_bus[3:0] = 4'h3; stall = 1'b1;
    step();
    check("stall_hold_a", 32'(out), 32'h1);
    step();
    check("stall_hold_b", 32'(out), 32'h1);
    step();
    check("stall_hold_c", 32'(out), 32'h1);
    check("stall_vld", 32'(out_vld), 32'h1);
    stall = 1'b0;
    step();
    check("stream_out2", 32'(out), 32'h2);
    in_vld = 1'b0;
    step();
    check("stream_out3", 32'(out), 32'h3);
    check("stream_vld3", 32'(out_vld), 32'h1);
    step();
    check("stream_drain", 32'(out_vld), 32'h0);

    // Flush beats stall; data fields hold
    in_bus[3:0] = 4'h4; in_vld = 1'b1;
    step();
    in_bus[3:0] = 4'h5;
    step();
    check("fill_out", 32'(out), 32'h4);
    check("fill_vld", 32'(out_vld), 32'h1);
    chk_addr = 4'h5;
    #1;
    check("fill_hazard", 32'(hazard), 32'h1);
    flush = 1'b1; stall = 1'b1; in_bus[3:0] = 4'h9;
    step();
    check("flush_vld", 32'(out_vld), 32'h0);
    check("flush_hazard", 32'(hazard), 32'h0);
    check("flush_data_hold", 32'(out), 32'h4);
    flush = 1'b0; stall = 1'b0; in_vld = 1'b0;
    step();
    check("flush_drop_a", 32'(out_vld), 32'h0);
    step();
    check("flush_drop_b", 32'(out_vld), 32'h0);

    // Hazard: s0 = 5 valid, s1 = 5 invalid
    in_bus[3:0] = 4'h5; in_vld = 1'b0;
    step();
    in_vld = 1'b1;
    step();
    for (int a = 0; a < 16; a++) begin
      chk_addr = 4'(a);
      #1;
      check($sformatf("hz_sweep_%0d", a), 32'(hazard), (a == 5) ? 32'h1 : 32'h0);
    end
    in_bus[3:0] = 4'h0; in_vld = 1'b0;
    step();
    chk_addr = 4'h5;
    #1;
    check("hz_s1_match", 32'(hazard), 32'h1);
    chk_addr = 4'h0;
    #1;
    check("hz_s0_invalid", 32'(hazard), 32'h0);
    step();
    chk_addr = 4'h5;
    #1;
    check("hz_gone", 32'(hazard), 32'h0);

    // Async reset between edges with entries in flight
    in_bus = {4'hC, 4'h7, 4'h3}; sel = 2'd1; in_vld = 1'b1;
    step();
    sel = 2'd3;
    step();
    check("pre_rst_out", 32'(out), 32'h7);
    check("pre_rst_vld", 32'(out_vld), 32'h1);
    #2;
    rst_f = 1'b0;
    #1;
    check("async_out", 32'(out), 32'h0);
    check("async_vld", 32'(out_vld), 32'h0);
    check("async_sel_err", 32'(sel_err), 32'h0);
    check("async_hazard", 32'(hazard), 32'h0);
    @(negedge clk);
    rst_f = 1'b1; sel = 2'd3; in_vld = 1'b0;

    // sel_err must not set without a live capture
    step();
    check("oor_novld_err", 32'(sel_err), 32'h0);
    in_vld = 1'b1; stall = 1'b1;
    step();
    check("oor_stall_err", 32'(sel_err), 32'h0);
    check("oor_stall_vld", 32'(out_vld), 32'h0);
    stall = 1'b0;
    step();
    check("oor_set_err", 32'(sel_err), 32'h1);
    in_vld = 1'b0;
    step();
    check("last_good_reset_out", 32'(out), 32'h0);
    check("last_good_reset_vld", 32'(out_vld), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
